// File: rtl/rng_scheduler.sv
// Round-robin front end for the shared xorshift128 PRNG: seed/warm-up sequencing
// and per-grant uniform sampling in [0, bound) by masked rejection.
module rng_scheduler #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int WARMUP    = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [127:0]            seed,
    input  logic                    reseed,
    output logic                    rng_rst,
    input  logic [31:0]             rng_out,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   bound,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        rand_data,
    output logic                    ready
);

    localparam int SW = $clog2(NREQ);
    localparam int WW = $clog2(WARMUP + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {SEED, WARM, IDLE, SAMPLE, ACK} state_t;

    state_t          state;
    logic [SW-1:0]   rr_ptr, sel, pick;
    logic            pick_vld;
    logic [WIDTH-1:0] bnd, cand, mask;
    logic            accept;
    logic            reseed_pending;
    logic [WW-1:0]   wcnt;
    logic [TW-1:0]   tries;

    // seed is wired straight to the PRNG; this block only sequences its load
    logic unused_bits;
    assign unused_bits = ^{seed, rng_out[31:WIDTH]};

    function automatic logic [WIDTH-1:0] mask_of(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] m;
        m = b - WIDTH'(1);
        for (int s = 1; s < WIDTH; s = s * 2)
            m = m | (m >> s);
        return m;
    endfunction

    // first requester at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx[SW-1:0];
            end
        end
    end

    assign mask    = mask_of(bnd);
    assign cand    = rng_out[WIDTH-1:0] & mask;
    assign accept  = (bnd == '0) || (cand < bnd);
    assign ready   = (state == IDLE) || (state == SAMPLE) || (state == ACK);
    assign rng_rst = (state == SEED) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SEED;
            ack            <= '0;
            rand_data      <= '0;
            rr_ptr         <= '0;
            sel            <= '0;
            bnd            <= '0;
            reseed_pending <= 1'b0;
            wcnt           <= '0;
            tries          <= '0;
        end else begin
            ack       <= '0;
            rand_data <= '0;
            if (reseed) reseed_pending <= 1'b1;
            case (state)
                SEED: begin
                    wcnt  <= '0;
                    state <= WARM;
                end
                WARM: begin
                    if (wcnt == WW'(WARMUP - 1)) state <= IDLE;
                    else                         wcnt  <= wcnt + WW'(1);
                end
                IDLE: begin
                    if (reseed_pending) begin
                        reseed_pending <= reseed;
                        state          <= SEED;
                    end else if (pick_vld) begin
                        sel   <= pick;
                        bnd   <= bound[pick*WIDTH +: WIDTH];
                        tries <= '0;
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (accept) begin
                        rand_data <= cand;
                        ack       <= NREQ'(1) << sel;
                        state     <= ACK;
                    end else if (tries == TW'(MAX_TRIES - 1)) begin
                        // mask < 2*bound, so this stays below bound
                        rand_data <= cand - bnd;
                        ack       <= NREQ'(1) << sel;
                        state     <= ACK;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                ACK: begin
                    rr_ptr <= (sel == SW'(NREQ - 1)) ? '0 : sel + SW'(1);
                    state  <= IDLE;
                end
                default: state <= SEED;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_scheduler.sv
// Self-checking bench for rng_scheduler: vector table, random transactions against a
// rejection-sampling model, fairness, reseed/reset corners and xorshift distribution.
module tb_rng_scheduler;
    localparam int NREQ = 4, WIDTH = 8, WARMUP = 16, MAX_TRIES = 8;

    logic clk = 1'b0, rst = 1'b1, reseed = 1'b0;
    logic [127:0] seed = 128'h12345678_9abcdef0_0fedcba9_87654321;
    logic rng_rst, ready;
    logic [31:0] rng_out, drv_rng = '0;
    logic use_prng = 1'b0;
    logic [NREQ-1:0] req = '0, ack;
    logic [NREQ*WIDTH-1:0] bound = '0;
    logic [WIDTH-1:0] rand_data;

    int errors = 0, checks = 0;
    logic [31:0] vals [MAX_TRIES];

    always #5 clk = ~clk;

    rng_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .WARMUP(WARMUP), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .rst(rst), .seed(seed), .reseed(reseed), .rng_rst(rng_rst),
        .rng_out(rng_out), .req(req), .bound(bound), .ack(ack),
        .rand_data(rand_data), .ready(ready)
    );

    // xorshift128 device standing in for the real PRNG
    logic [31:0] px = 32'h1, py = 32'h2, pz = 32'h3, pw = 32'h4;
    function automatic logic [31:0] xs_next(input logic [31:0] x, input logic [31:0] w);
        logic [31:0] t;
        t = x ^ (x << 11);
        return w ^ (w >> 19) ^ t ^ (t >> 8);
    endfunction
    always @(posedge clk) begin
        if (rng_rst) begin
            {px, py, pz, pw} <= seed;
        end else begin
            px <= py; py <= pz; pz <= pw;
            pw <= xs_next(px, pw);
        end
    end
    assign rng_out = use_prng ? pw : drv_rng;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    function automatic logic [WIDTH-1:0] ref_mask(input logic [WIDTH-1:0] b);
        if (b == '0) return '1;
        for (int k = 0; k <= WIDTH; k++)
            if (((1 << k) - 1) >= int'(b) - 1) return WIDTH'((1 << k) - 1);
        return '1;
    endfunction

    // Starts in an IDLE cycle; j is the try index expected to produce the ack.
    task automatic do_txn(input int r, input logic [WIDTH-1:0] b, input int j,
                          input logic [WIDTH-1:0] exp, input int rs_at, input string nm);
        logic [NREQ-1:0] oh;
        oh = '0; oh[r] = 1'b1;
        req = oh;
        bound[r*WIDTH +: WIDTH] = b;
        drv_rng = vals[0];
        step();
        chk({nm, "_ack_idle"}, 32'(ack), 0);
        for (int k = 0; k < MAX_TRIES; k++) begin
            reseed = (k == rs_at);
            drv_rng = vals[k];
            step();
            if (k == j) begin
                chk({nm, "_ack"}, 32'(ack), 32'(oh));
                chk({nm, "_data"}, 32'(rand_data), 32'(exp));
                break;
            end
            chk({nm, "_noack"}, 32'(ack), 0);
        end
        reseed = 1'b0;
        req = '0;
        step();
        chk({nm, "_post"}, 32'({ack, rand_data}), 0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] b;
        logic [31:0]      rng;
        logic [WIDTH-1:0] exp;
        int               j;
    } vec_t;
    vec_t tbl [11];

    initial begin
        int order [6];
        int n, cyc, hist [5];
        logic [WIDTH-1:0] b, m, cnd, e;
        int j, r, lat;
        bit got;

        tbl[0]  = '{8'd5,   32'h3,         8'd3,   0};
        tbl[1]  = '{8'd1,   32'hFFFF_FFFF, 8'd0,   0};
        tbl[2]  = '{8'd0,   32'hAB,        8'hAB,  0};
        tbl[3]  = '{8'd129, 32'hFF,        8'd126, 7};
        tbl[4]  = '{8'd5,   32'h7,         8'd2,   7};
        tbl[5]  = '{8'd200, 32'hFFFF_00C7, 8'd199, 0};
        tbl[6]  = '{8'd16,  32'h1F,        8'd15,  0};
        tbl[7]  = '{8'd17,  32'h1F,        8'd14,  7};
        tbl[8]  = '{8'd2,   32'h2,         8'd0,   0};
        tbl[9]  = '{8'd3,   32'h3,         8'd0,   7};
        tbl[10] = '{8'd255, 32'hFE,        8'hFE,  0};

        // startup with every requester already asking
        req = '1;
        repeat (3) step();
        chk("rst_rng_rst", 32'(rng_rst), 0);
        chk("rst_outputs", 32'({ack, rand_data, ready}), 0);
        rst = 1'b0;
        #1;
        chk("seed_pulse", 32'(rng_rst), 1);
        for (int c = 1; c <= WARMUP + 1; c++) begin
            step();
            chk("warm_rng_rst", 32'(rng_rst), 0);
            chk("warm_ack", 32'(ack), 0);
            if (c == WARMUP || c == WARMUP + 1) chk("warm_ready", 32'(ready), 32'(c == WARMUP + 1));
        end

        // fairness: all four held and re-raised after each grant
        n = 0;
        for (cyc = 0; cyc < 60 && n < 6; cyc++) begin
            step();
            if (ack != '0) begin
                chk("fair_onehot", 32'($onehot(ack)), 1);
                order[n] = $clog2(ack);
                chk("fair_order", 32'(order[n]), 32'(n % NREQ));
                n++;
                req = n < 6 ? ~ack : '0;
            end else if (n < 6) begin
                req = '1;
            end
        end
        chk("fair_count", 32'(n), 6);
        step();
        req = 4'b0011;
        n = 0;
        for (cyc = 0; cyc < 20 && n < 2; cyc++) begin
            step();
            if (ack != '0) begin
                chk("rr_wrap", 32'(ack), n == 0 ? 32'h1 : 32'h2);
                n++;
                req = req & ~ack;
            end
        end
        chk("rr_wrap_count", 32'(n), 2);
        req = '0;
        step();

        // vector table
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < MAX_TRIES; k++) vals[k] = tbl[i].rng;
            do_txn(i % NREQ, tbl[i].b, tbl[i].j, tbl[i].exp, -1, $sformatf("vec%0d", i));
        end

        // random transactions against the rejection-sampling model
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, NREQ - 1);
            b = WIDTH'($urandom_range(0, 255));
            for (int k = 0; k < MAX_TRIES; k++) vals[k] = $urandom;
            m = ref_mask(b);
            j = -1;
            e = '0;
            for (int k = 0; k < MAX_TRIES; k++) begin
                cnd = vals[k][WIDTH-1:0] & m;
                if (b == '0 || cnd < b) begin j = k; e = cnd; break; end
            end
            if (j < 0) begin
                j = MAX_TRIES - 1;
                e = (vals[j][WIDTH-1:0] & m) - b;
            end
            do_txn(r, b, j, e, -1, $sformatf("rnd%0d", t));
        end

        // reseed while sampling: grant finishes, then a full seed/warm sequence
        for (int k = 0; k < MAX_TRIES; k++) vals[k] = 32'hFF;
        do_txn(2, 8'd129, 7, 8'd126, 2, "reseed_txn");
        step();
        chk("reseed_pulse", 32'({rng_rst, ready}), 32'b10);
        for (int c = 1; c <= WARMUP; c++) begin
            step();
            chk("reseed_warm", 32'({rng_rst, ready}), 0);
        end
        step();
        chk("reseed_ready", 32'(ready), 1);
        for (int k = 0; k < MAX_TRIES; k++) vals[k] = 32'h3;
        do_txn(3, 8'd5, 0, 8'd3, -1, "after_reseed");

        // reset while sampling: no ack, held req served after startup
        req = 4'b0010;
        bound[1*WIDTH +: WIDTH] = 8'd129;
        drv_rng = 32'hFF;
        step();
        step();
        chk("rstmid_noack", 32'(ack), 0);
        rst = 1'b1;
        step();
        chk("rstmid_held", 32'({ack, rng_rst, ready}), 0);
        rst = 1'b0;
        #1;
        chk("rstmid_seed", 32'(rng_rst), 1);
        for (int c = 1; c <= WARMUP + 1; c++) begin
            step();
            chk("rstmid_warm_ack", 32'(ack), 0);
        end
        chk("rstmid_ready", 32'(ready), 1);
        drv_rng = 32'h3;
        step();
        chk("rstmid_sample", 32'(ack), 0);
        step();
        chk("rstmid_ack", 32'(ack), 32'h2);
        chk("rstmid_data", 32'(rand_data), 3);
        req = '0;
        step();

        // distribution with the xorshift device
        use_prng = 1'b1;
        reseed = 1'b1;
        step();
        reseed = 1'b0;
        got = 1'b0;
        for (cyc = 0; cyc < 8; cyc++) begin
            step();
            if (rng_rst) got = 1'b1;
        end
        chk("dist_seed_seen", 32'(got), 1);
        for (cyc = 0; cyc < WARMUP + 8 && !ready; cyc++) step();
        chk("dist_ready", 32'(ready), 1);
        for (int v = 0; v < 5; v++) hist[v] = 0;
        bound[0 +: WIDTH] = 8'd5;
        for (int t = 0; t < 4000; t++) begin
            req = 4'b0001;
            got = 1'b0;
            lat = 0;
            for (int c = 1; c <= MAX_TRIES + 2 && !got; c++) begin
                step();
                if (ack != '0) begin got = 1'b1; lat = c; end
            end
            if (!got || lat > MAX_TRIES + 1 || ack != 4'b0001 || rand_data > 8'd4)
                chk("dist_txn", 32'({got, ack, rand_data}), 32'({1'b1, 4'b0001, 8'd0}));
            else begin
                checks++;
                hist[rand_data]++;
            end
            req = '0;
            step();
        end
        for (int v = 0; v < 5; v++) chk($sformatf("dist_hist%0d", v), 32'(hist[v] >= 600), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
